// File: rtl/comet_ii_fetch_sequencer_if.sv
// comet_ii_fetch_sequencer_if: req/ack instruction-memory read port between the sequencer and memory.
interface comet_ii_fetch_sequencer_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/comet_ii_fetch_sequencer.sv
// comet_ii_fetch_sequencer: COMET II control sequencer owning PR and the instruction fetch port.
// Defining COMET_II_ILLEGAL_OP_TRAP_EN adds o_illegal_op and traps unknown opcodes back to IDLE.
module comet_ii_fetch_sequencer #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic [AW-1:0]              i_start_addr,
    input  logic                       i_halt_req,
    comet_ii_fetch_sequencer_if.master mem,
    input  logic                       i_exec_busy,
    input  logic                       i_jump,
    input  logic [AW-1:0]              i_jump_addr,
    output logic [2:0]                 o_state,
    output logic [7:0]                 o_op_code,
    output logic [7:0]                 o_regs,
    output logic [AW-1:0]              o_adr,
    output logic                       o_adr_en,
    output logic [AW-1:0]              o_pr,
    output logic                       o_running
`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
    ,
    output logic                       o_illegal_op
`endif
);
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        INIT  = 3'b001,
        IFET1 = 3'b010,
        IFET2 = 3'b011,
        EXEC  = 3'b100,
        WBACK = 3'b101
    } state_t;

    state_t        r_state;
    logic [7:0]    r_op;
    logic [7:0]    r_regs;
    logic [AW-1:0] r_adr;
    logic          r_adr_en;
    logic [AW-1:0] r_pr;
    logic          r_jmp_pend;
    logic [AW-1:0] r_jmp_tgt;
    logic [7:0]    w_op;
    logic          w_one;

    function automatic logic f_one_word(input logic [7:0] op);
        return op == 8'h00 || op == 8'h71 || op == 8'h81 ||
               (op[7:4] >= 4'h1 && op[7:4] <= 4'h4 && op[2]);
    endfunction

    assign w_op  = mem.mem_rdata[DW-1 -: 8];
    assign w_one = f_one_word(w_op);

`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
    logic r_illegal;
    logic w_legal;

    function automatic logic f_legal(input logic [7:0] op);
        case (op[7:4])
            4'h0:    return op[3:0] == 4'h0;
            4'h1:    return op[3:0] <= 4'h2 || op[3:0] == 4'h4;
            4'h2:    return !op[3];
            4'h3:    return !op[3] && op[1:0] != 2'b11;
            4'h4:    return op[3:2] == 2'b00 ? op[1:0] <= 2'b01 : op[3:0] <= 4'h5;
            4'h5:    return op[3:2] == 2'b00;
            4'h6:    return op[3:0] >= 4'h1 && op[3:0] <= 4'h6;
            4'h7:    return op[3:1] == 3'b000;
            4'h8:    return op[3:1] == 3'b000;
            4'hF:    return op[3:0] == 4'h0;
            default: return 1'b0;
        endcase
    endfunction

    assign w_legal      = f_legal(w_op);
    assign o_illegal_op = r_illegal;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_regs     <= '0;
            r_adr      <= '0;
            r_adr_en   <= 1'b0;
            r_pr       <= '0;
            r_jmp_pend <= 1'b0;
            r_jmp_tgt  <= '0;
`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_state <= INIT;
`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
                    r_illegal <= 1'b0;
`endif
                end
                INIT: begin
                    r_pr       <= i_start_addr;
                    r_op       <= '0;
                    r_regs     <= '0;
                    r_adr      <= '0;
                    r_jmp_pend <= 1'b0;
                    r_state    <= IFET1;
                end
                IFET1: if (mem.mem_ack) begin
                    r_op     <= w_op;
                    r_regs   <= mem.mem_rdata[7:0];
                    r_pr     <= r_pr + AW'(1);
                    r_adr_en <= !w_one;
                    if (w_one) r_adr <= '0;
                    r_state  <= w_one ? EXEC : IFET2;
`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
                    if (!w_legal) begin
                        r_state   <= IDLE;
                        r_illegal <= 1'b1;
                    end
`endif
                end
                IFET2: if (mem.mem_ack) begin
                    r_adr   <= AW'(mem.mem_rdata);
                    r_pr    <= r_pr + AW'(1);
                    r_state <= EXEC;
                end
                EXEC: if (!i_exec_busy) begin
                    r_jmp_pend <= i_jump;
                    if (i_jump) r_jmp_tgt <= i_jump_addr;
                    r_state    <= WBACK;
                end
                WBACK: begin
                    if (r_jmp_pend) r_pr <= r_jmp_tgt;
                    r_jmp_pend <= 1'b0;
                    r_state    <= i_halt_req ? IDLE : IFET1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory port decodes purely from registered state, so no input reaches it combinationally.
    assign mem.mem_req  = r_state == IFET1 || r_state == IFET2;
    assign mem.mem_addr = r_pr;
    assign o_state      = r_state;
    assign o_op_code    = r_op;
    assign o_regs       = r_regs;
    assign o_adr        = r_adr;
    assign o_adr_en     = r_adr_en;
    assign o_pr         = r_pr;
    assign o_running    = r_state != IDLE;
endmodule

// File: tb/tb_comet_ii_fetch_sequencer.sv
// tb_comet_ii_fetch_sequencer: directed plan steps plus a randomized instruction stream against a program-level model.
module tb_comet_ii_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic        halt_req = 1'b0;
    logic        exec_busy = 1'b0;
    logic        jump = 1'b0;
    logic [15:0] jump_addr = '0;
    logic [2:0]  state;
    logic [7:0]  op_code;
    logic [7:0]  regs;
    logic [15:0] adr;
    logic        adr_en;
    logic [15:0] pr;
    logic        running;
`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
    logic        illegal_op;
`endif

    int ntests = 0;
    int nfail = 0;
    int lat = 0;
    int wcnt = 0;
    logic [15:0] mem [0:65535];
    logic [15:0] pc;
    logic [7:0]  one_q[$];
    logic [7:0]  legal_ops[$] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h14, 8'h20, 8'h21, 8'h22, 8'h23,
                                 8'h24, 8'h25, 8'h26, 8'h27, 8'h30, 8'h31, 8'h32, 8'h34, 8'h35,
                                 8'h36, 8'h40, 8'h41, 8'h44, 8'h45, 8'h50, 8'h51, 8'h52, 8'h53,
                                 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h70, 8'h71, 8'h80,
                                 8'h81, 8'hF0};

    comet_ii_fetch_sequencer_if #(.AW(16), .DW(16)) bus ();

    comet_ii_fetch_sequencer #(.AW(16), .DW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_start_addr (start_addr),
        .i_halt_req   (halt_req),
        .mem          (bus.master),
        .i_exec_busy  (exec_busy),
        .i_jump       (jump),
        .i_jump_addr  (jump_addr),
        .o_state      (state),
        .o_op_code    (op_code),
        .o_regs       (regs),
        .o_adr        (adr),
        .o_adr_en     (adr_en),
        .o_pr         (pr),
        .o_running    (running)
`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
        ,
        .o_illegal_op (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    // Memory answers after `lat` extra wait cycles of a held request.
    always @(posedge clk) wcnt <= (!bus.mem_req || bus.mem_ack) ? 0 : wcnt + 1;
    assign bus.mem_ack   = bus.mem_req && (wcnt >= lat);
    assign bus.mem_rdata = mem[bus.mem_addr];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            step();
            n++;
        end
        chk("wait_state", 32'(state), 32'(s));
    endtask

    function automatic bit is_one(input logic [7:0] op);
        foreach (one_q[i]) if (one_q[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic rand_instr();
        logic [7:0]  op;
        logic [15:0] w1, w2, tgt, a2, seq, nxt;
        bit          two, jmp;
        int          l, b, n;
        op  = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
        w1  = {op, 8'($urandom)};
        w2  = 16'($urandom);
        two = !is_one(op);
        a2  = pc + 16'd1;
        seq = pc + (two ? 16'd2 : 16'd1);
        mem[pc] = w1;
        if (two) mem[a2] = w2;
        l   = $urandom_range(0, 3);
        b   = $urandom_range(0, 3);
        jmp = 1'($urandom_range(0, 1));
        tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        lat = l;
        exec_busy = 1'($urandom);
        jump      = 1'($urandom);
        jump_addr = 16'($urandom);
        chk("r_ifet1", 32'(state), 32'h2);
        chk("r_addr1", 32'(bus.mem_addr), 32'(pc));
        n = 0;
        do begin step(); n++; end while (state == 3'b010 && n < 20);
        chk("r_lat1", 32'(n), 32'(l + 1));
        if (two) begin
            chk("r_ifet2", 32'(state), 32'h3);
            chk("r_addr2", 32'(bus.mem_addr), 32'(a2));
            n = 0;
            do begin step(); n++; end while (state == 3'b011 && n < 20);
            chk("r_lat2", 32'(n), 32'(l + 1));
        end
        chk("r_exec", 32'(state), 32'h4);
        chk("r_op", 32'(op_code), 32'(op));
        chk("r_regs", 32'(regs), 32'(w1[7:0]));
        chk("r_adr", 32'(adr), two ? 32'(w2) : 32'h0);
        chk("r_adr_en", 32'(adr_en), 32'(two));
        chk("r_pr_exec", 32'(pr), 32'(seq));
        exec_busy = 1'b1;
        jump      = 1'b1;
        jump_addr = ~tgt;
        repeat (b) begin
            step();
            chk("r_busy", 32'(state), 32'h4);
        end
        exec_busy = 1'b0;
        jump      = jmp;
        jump_addr = tgt;
        step();
        jump = 1'b0;
        chk("r_wback", 32'(state), 32'h5);
        nxt = jmp ? tgt : seq;
        pc  = nxt;
        step();
        chk("r_pr_next", 32'(pr), 32'(pc));
    endtask

    initial begin
        one_q = '{8'h00, 8'h71, 8'h81};
        for (int h = 1; h <= 4; h++)
            for (int l = 0; l < 16; l++)
                if (l[2]) one_q.push_back(8'(h * 16 + l));
        mem[16'h0100] = 16'h1012;
        mem[16'h0101] = 16'h0200;
        mem[16'h0200] = 16'h2412;
        mem[16'h0201] = 16'h0000;
        mem[16'h0202] = 16'h6400;
        mem[16'h0203] = 16'h0300;
        mem[16'h0300] = 16'h0000;

        #3 rst_n = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_op", 32'(op_code), 32'h0);
        chk("rst_regs", 32'(regs), 32'h0);
        chk("rst_adr", 32'(adr), 32'h0);
        chk("rst_adr_en", 32'(adr_en), 32'h0);
        chk("rst_pr", 32'(pr), 32'h0);
        chk("rst_req", 32'(bus.mem_req), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
        chk("rst_illegal", 32'(illegal_op), 32'h0);
`endif
        rst_n = 1'b1;
        step();
        chk("idle_hold", 32'(state), 32'h0);

        start_addr = 16'h0100;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_init", 32'(state), 32'h1);
        step();
        chk("t1_ifet1", 32'(state), 32'h2);
        chk("t1_addr1", 32'(bus.mem_addr), 32'h0100);
        chk("t1_req", 32'(bus.mem_req), 32'h1);
        step();
        chk("t1_ifet2", 32'(state), 32'h3);
        chk("t1_addr2", 32'(bus.mem_addr), 32'h0101);
        step();
        chk("t1_exec", 32'(state), 32'h4);
        chk("t1_op", 32'(op_code), 32'h10);
        chk("t1_regs", 32'(regs), 32'h12);
        chk("t1_adr", 32'(adr), 32'h0200);
        chk("t1_adr_en", 32'(adr_en), 32'h1);
        chk("t1_pr", 32'(pr), 32'h0102);
        chk("t1_noreq", 32'(bus.mem_req), 32'h0);
        jump = 1'b1;
        jump_addr = 16'h0200;
        step();
        jump = 1'b0;
        chk("t1_wback", 32'(state), 32'h5);
        step();
        chk("t1_ifet1b", 32'(state), 32'h2);
        chk("t1_jmp_addr", 32'(bus.mem_addr), 32'h0200);

        step();
        chk("t2_exec", 32'(state), 32'h4);
        chk("t2_op", 32'(op_code), 32'h24);
        chk("t2_adr", 32'(adr), 32'h0);
        chk("t2_adr_en", 32'(adr_en), 32'h0);
        chk("t2_pr", 32'(pr), 32'h0201);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_start_ignored", 32'(state), 32'h5);
        step();
        chk("t2_next", 32'(pr), 32'h0201);

        lat = 3;
        for (int i = 0; i < 4; i++) begin
            chk("t3_state", 32'(state), 32'h2);
            chk("t3_req", 32'(bus.mem_req), 32'h1);
            chk("t3_addr", 32'(bus.mem_addr), 32'h0201);
            step();
        end
        chk("t3_exec", 32'(state), 32'h4);
        chk("t3_pr", 32'(pr), 32'h0202);
        lat = 0;
        step();
        step();

        chk("t4_ifet1", 32'(state), 32'h2);
        step();
        step();
        chk("t4_exec", 32'(state), 32'h4);
        chk("t4_adr", 32'(adr), 32'h0300);
        chk("t4_pr", 32'(pr), 32'h0204);
        exec_busy = 1'b1;
        jump = 1'b1;
        jump_addr = 16'h1234;
        step();
        chk("t4_busy1", 32'(state), 32'h4);
        step();
        chk("t4_busy2", 32'(state), 32'h4);
        exec_busy = 1'b0;
        jump_addr = 16'h0300;
        step();
        jump = 1'b0;
        chk("t4_wback", 32'(state), 32'h5);
        step();
        chk("t4_pr_jmp", 32'(pr), 32'h0300);
        chk("t4_addr", 32'(bus.mem_addr), 32'h0300);

        halt_req = 1'b1;
        step();
        chk("t5_exec", 32'(state), 32'h4);
        step();
        chk("t5_wback", 32'(state), 32'h5);
        step();
        halt_req = 1'b0;
        chk("t5_idle", 32'(state), 32'h0);
        chk("t5_running", 32'(running), 32'h0);
        chk("t5_pr", 32'(pr), 32'h0301);
        step();
        chk("t5_pr_hold", 32'(pr), 32'h0301);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_init", 32'(state), 32'h1);
        step();
        chk("t5_resume", 32'(bus.mem_addr), 32'h0100);

        lat = 5;
        wait_state(3'b011, 20);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(bus.mem_req), 32'h0);
        chk("t6_state", 32'(state), 32'h0);
        chk("t6_outs", {op_code, regs, adr}, 32'h0);
        chk("t6_pr", 32'(pr), 32'h0);
        chk("t6_flags", {30'h0, adr_en, running}, 32'h0);
        step();
        rst_n = 1'b1;
        lat = 0;

        start_addr = 16'hFFFF;
        mem[16'hFFFF] = 16'h1012;
        mem[16'h0000] = 16'hABCD;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t7_addr1", 32'(bus.mem_addr), 32'hFFFF);
        step();
        chk("t7_addr2", 32'(bus.mem_addr), 32'h0000);
        step();
        chk("t7_exec", 32'(state), 32'h4);
        chk("t7_adr", 32'(adr), 32'hABCD);
        chk("t7_pr", 32'(pr), 32'h0001);
        step();
        step();
        pc = 16'h0001;

        for (int k = 0; k < 60; k++) rand_instr();

`ifdef COMET_II_ILLEGAL_OP_TRAP_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        lat = 0;
        exec_busy = 1'b0;
        jump = 1'b0;
        mem[16'h0400] = 16'h9000;
        start_addr = 16'h0400;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("trap_state", 32'(state), 32'h0);
        chk("trap_flag", 32'(illegal_op), 32'h1);
        chk("trap_pr", 32'(pr), 32'h0401);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("trap_clear", 32'(illegal_op), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
